// File: rtl/bon_pkg.sv
// Shared constants for the BON pattern-ROM arbiter slice.
// Requester indices double as the encoding of the round-robin priority bit.
package bon_pkg;
    localparam int BON_DW = 10;
    localparam int BON_AW = 10;
    localparam int BON_CW = 16;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;
endpackage

// File: rtl/bon_rr_arb2.sv
// Two-way round-robin arbiter: combinational grants plus the priority flop.
// The priority bit names the requester that wins the next contended cycle.
module bon_rr_arb2
    import bon_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1
);

    logic prio_reg;
    logic prio_next;

    always_comb begin
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        prio_next = prio_reg;
        // A low reset also blanks the grants so no ROM access leaks out.
        if (rst) begin
            if (req0 && (!req1 || prio_reg == REQ0)) begin
                gnt0 = 1'b1;
            end else if (req1) begin
                gnt1 = 1'b1;
            end
        end
        if (gnt0) begin
            prio_next = REQ1;
        end else if (gnt1) begin
            prio_next = REQ0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prio_reg <= REQ0;
        end else begin
            prio_reg <= prio_next;
        end
    end

endmodule

// File: rtl/bon_rom_arb.sv
// Shares one combinational-read pattern ROM between two scan engines, returning
// the word one cycle after the grant, with saturating per-requester grant counters.
module bon_rom_arb
    import bon_pkg::*;
#(
    parameter int DW = BON_DW,
    parameter int AW = BON_AW,
    parameter int CW = BON_CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic [AW-1:0] addr0,
    input  logic          req1,
    input  logic [AW-1:0] addr1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          mem_en,
    output logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_data,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata,
    input  logic          clr,
    output logic [CW-1:0] cnt0,
    output logic [CW-1:0] cnt1
);

    logic [1:0]    gnt_vec;
    logic [1:0]    rvalid_reg;
    logic [DW-1:0] rdata_reg;
    logic [CW-1:0] cnt_reg [2];

    bon_rr_arb2 u_arb (
        .clk  (clk),
        .rst  (rst),
        .req0 (req0),
        .req1 (req1),
        .gnt0 (gnt0),
        .gnt1 (gnt1)
    );

    assign gnt_vec = {gnt1, gnt0};
    assign mem_en  = gnt0 | gnt1;

    always_comb begin
        mem_addr = '0;
        if (gnt0) begin
            mem_addr = addr0;
        end else if (gnt1) begin
            mem_addr = addr1;
        end
    end

    // rdata keeps its last value across idle cycles; only rvalid drops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rvalid_reg <= 2'b00;
            rdata_reg  <= '0;
        end else begin
            rvalid_reg <= gnt_vec;
            if (mem_en) begin
                rdata_reg <= mem_data;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    cnt_reg[gi] <= '0;
                end else if (clr) begin
                    cnt_reg[gi] <= '0;
                end else if (gnt_vec[gi] && cnt_reg[gi] != {CW{1'b1}}) begin
                    cnt_reg[gi] <= cnt_reg[gi] + 1'b1;
                end
            end
        end
    endgenerate

    assign rvalid0 = rvalid_reg[0];
    assign rvalid1 = rvalid_reg[1];
    assign rdata   = rdata_reg;
    assign cnt0    = cnt_reg[0];
    assign cnt1    = cnt_reg[1];

endmodule
